// File: rtl/rmw_memory_pkg.sv
// rmw_memory_pkg: command opcodes, FSM states and response decode shared by rmw_memory
package rmw_memory_pkg;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    INC_RD,
    INC_WR,
    CLR,
    CLR_DONE
  } state_t;
  function automatic logic responds(input state_t s);
    return s == RD || s == WR || s == INC_WR || s == CLR_DONE;
  endfunction
endpackage

// File: rtl/rmw_memory_ram_sp.sv
// ram_sp: single-port RAM, 1-cycle read latency, no reset.
// Ports: clk; a word address; din write data; we write enable; dout registered read data.
// RAM_BYPASS_EN defined selects write-first, otherwise a same-address read returns the old word.
module ram_sp
  import rmw_memory_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] a,
  input  logic [WIDTH-1:0]         din,
  input  logic                     we,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[a] <= din;
`ifdef RAM_BYPASS_EN
    dout <= we ? din : mem[a];
`else
    dout <= mem[a];
`endif
  end
endmodule

// File: rtl/rmw_memory.sv
// rmw_memory: single-port RAM behind a valid/ready port with READ, WRITE, atomic INC and CLEAR-all.
// Ports: clk; reset (sync, active high); cmd_valid/cmd_ready handshake; cmd_op (00 rd, 01 wr,
// 10 inc, 11 clear); cmd_addr; cmd_data; rsp_valid one-cycle completion pulse; rsp_data result
// (held between pulses); busy high whenever not idle.
// RAM_BYPASS_EN defined makes the RAM write-first, so a WRITE responds with its own data.
module rmw_memory
  import rmw_memory_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(DEPTH)-1:0] cmd_addr,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  op_t op;
  logic [AW-1:0] addr, cnt, ram_a;
  logic [WIDTH-1:0] ram_din, ram_dout, rsp_q, inc;
  logic ram_we, accept, last;
  assign op = op_t'(cmd_op);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign last = cnt == AW'(DEPTH - 1);
  assign inc = ram_dout + WIDTH'(1);
  assign rsp_valid = responds(state);
  // READ/WRITE results come straight off the RAM in their response cycle; everything else is registered
  assign rsp_data = (state == RD || state == WR) ? ram_dout : rsp_q;
  // The address is presented combinationally at accept so the read completes at the accept edge
  assign ram_a = state == IDLE ? cmd_addr : state == CLR ? cnt : addr;
  assign ram_din = state == INC_RD ? inc : state == CLR ? '0 : cmd_data;
  // Writes are suppressed while reset is asserted so an aborted sweep stops at word k-1
  assign ram_we = !reset && (state == INC_RD || state == CLR || (accept && op == OP_WRITE));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == CLR ? cnt + AW'(1) : '0;
      if (accept) addr <= cmd_addr;
      if (state == RD || state == WR) rsp_q <= ram_dout;
      else if (state == INC_RD) rsp_q <= inc;
      else if (state == CLR && last) rsp_q <= '0;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = op == OP_READ ? RD : op == OP_WRITE ? WR : op == OP_INC ? INC_RD : CLR;
      INC_RD:  state_n = INC_WR;
      CLR:     state_n = last ? CLR_DONE : CLR;
      default: state_n = IDLE;
    endcase
  end
  ram_sp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk (clk),
    .a   (ram_a),
    .din (ram_din),
    .we  (ram_we),
    .dout(ram_dout)
  );
endmodule

// File: tb/tb_rmw_memory.sv
// tb_rmw_memory: vector table, hand sequences and random traffic against an array model
module tb_rmw_memory;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] rsp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic v8 = 1'b0, v4 = 1'b0;
  logic r8, rv8, b8, r4, rv4, b4;
  logic [7:0] rd8;
  logic [3:0] rd4;
  int errors = 0, checks = 0;
  logic [7:0] m [16];
  bit kn [16];
  vec_t vt [$];
  always #5 clk = ~clk;
  rmw_memory #(.WIDTH(8), .DEPTH(16)) u8 (
    .clk(clk), .reset(reset), .cmd_valid(v8), .cmd_ready(r8), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rv8), .rsp_data(rd8), .busy(b8)
  );
  rmw_memory #(.WIDTH(4), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .cmd_valid(v4), .cmd_ready(r4), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr[1:0]), .cmd_data(cmd_data[3:0]), .rsp_valid(rv4), .rsp_data(rd4), .busy(b4)
  );
  function automatic logic rdy(input bit s);
    return s ? r4 : r8;
  endfunction
  function automatic logic rvs(input bit s);
    return s ? rv4 : rv8;
  endfunction
  function automatic logic bsy(input bit s);
    return s ? b4 : b8;
  endfunction
  function automatic int exp_lat(input logic [1:0] op, input bit s);
    return op == 2'd3 ? (s ? 5 : 17) : op == 2'd2 ? 2 : 1;
  endfunction
  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d, input logic [7:0] rsp);
    return {op, a, d, rsp};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_cmd(input bit s, input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] r, output int lat, output int bad);
    int w;
    w = 0;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    while (!rdy(s) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("ready timeout", 0, 1);
    if (s) v4 = 1'b1;
    else v8 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    v8 = 1'b0;
    cmd_data = ~d;
    cmd_addr = ~a;
    lat = 1;
    bad = 0;
    while (!rvs(s) && lat < 40) begin
      bad += int'(rdy(s) || !bsy(s));
      @(negedge clk);
      lat++;
    end
    bad += int'(rdy(s) || !bsy(s));
    r = s ? {4'h0, rd4} : rd8;
    @(negedge clk);
    bad += int'(rvs(s) || !rdy(s));
  endtask
  task automatic issue(input bit s, input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] exp, input bit cd, input string nm);
    logic [7:0] r;
    int lat, bad;
    do_cmd(s, op, a, d, r, lat, bad);
    chk({nm, " latency"}, lat, exp_lat(op, s));
    chk({nm, " handshake"}, bad, 0);
    if (cd) chk({nm, " data"}, {24'h0, r}, {24'h0, exp});
    if (!s) begin
      if (op == 2'd1) begin
        m[a] = d;
        kn[a] = 1'b1;
      end else if (op == 2'd2) m[a] = m[a] + 8'd1;
      else if (op == 2'd3) for (int i = 0; i < 16; i++) begin
        m[i] = 8'h00;
        kn[i] = 1'b1;
      end
    end
  endtask
  initial begin
    int nr, r;
    logic [1:0] op;
    logic [3:0] a;
    logic [7:0] d, e, old9;
    bit cd;
    for (int i = 0; i < 16; i++) kn[i] = 1'b0;
    vt.push_back(mk(2'd3, 4'd0, 8'h00, 8'h00));
    for (int i = 0; i < 16; i++) vt.push_back(mk(2'd0, 4'(i), 8'h00, 8'h00));
    vt.push_back(mk(2'd1, 4'd3, 8'hA5, BYP ? 8'hA5 : 8'h00));
    vt.push_back(mk(2'd0, 4'd3, 8'h00, 8'hA5));
    vt.push_back(mk(2'd1, 4'd7, 8'hFE, BYP ? 8'hFE : 8'h00));
    vt.push_back(mk(2'd2, 4'd7, 8'h00, 8'hFF));
    vt.push_back(mk(2'd2, 4'd7, 8'h00, 8'h00));
    repeat (3) @(negedge clk);
    chk("reset ready", r8, 1);
    chk("reset rsp_valid", rv8, 0);
    chk("reset rsp_data", rd8, 0);
    chk("reset busy", b8, 0);
    chk("reset4 ready/busy", {r4, b4, rv4}, 3'b100);
    chk("reset4 rsp_data", rd4, 0);
    reset = 1'b0;
    @(negedge clk);
    foreach (vt[i]) issue(0, vt[i].op, vt[i].a, vt[i].d, vt[i].rsp, 1'b1, $sformatf("vec%0d", i));
    // busy hold: WRITE held valid during an INC, only the accept-cycle data must land
    cmd_op = 2'd2;
    cmd_addr = 4'd2;
    v8 = 1'b1;
    @(negedge clk);
    old9 = m[9];
    cmd_op = 2'd1;
    cmd_addr = 4'd9;
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      if (rv8) begin
        nr++;
        chk("hold inc data", rd8, m[2] + 8'd1);
      end
      cmd_data = 8'h20 + 8'(i);
      @(negedge clk);
    end
    v8 = 1'b0;
    chk("hold inc rsp count", nr, 1);
    chk("hold write rsp", rv8, 1);
    chk("hold write data", rd8, BYP ? 8'h22 : old9);
    m[2] = m[2] + 8'd1;
    m[9] = 8'h22;
    @(negedge clk);
    chk("hold idle", {rv8, r8}, 2'b01);
    issue(0, 2'd0, 4'd9, 8'h00, 8'h22, 1'b1, "hold readback");
    // reset in the middle of a CLEAR sweep
    issue(0, 2'd1, 4'd15, 8'h3C, m[15], 1'b1, "pre-clear write");
    cmd_op = 2'd3;
    v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    nr = 0;
    repeat (4) begin
      nr += int'(rv8);
      @(negedge clk);
    end
    reset = 1'b1;
    nr += int'(rv8);
    @(negedge clk);
    reset = 1'b0;
    chk("abort no rsp", nr, 0);
    chk("abort idle", {rv8, r8, b8}, 3'b010);
    chk("abort rsp_data", rd8, 0);
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    kn[4] = 1'b0;
    for (int i = 0; i < 4; i++) issue(0, 2'd0, 4'(i), 8'h00, 8'h00, 1'b1, $sformatf("abort rd%0d", i));
    issue(0, 2'd0, 4'd15, 8'h00, 8'h3C, 1'b1, "abort rd15");
    issue(0, 2'd0, 4'd7, 8'h00, m[7], 1'b1, "abort rd7");
    // narrow instance
    issue(1, 2'd3, 4'd0, 8'h00, 8'h00, 1'b1, "w4 clear");
    issue(1, 2'd1, 4'd1, 8'h0F, BYP ? 8'h0F : 8'h00, 1'b1, "w4 write");
    issue(1, 2'd2, 4'd1, 8'h00, 8'h00, 1'b1, "w4 inc wrap");
    issue(1, 2'd2, 4'd2, 8'h00, 8'h01, 1'b1, "w4 inc");
    issue(1, 2'd0, 4'd1, 8'h00, 8'h00, 1'b1, "w4 read");
    // random traffic against the array model
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      op = r == 0 ? 2'd3 : r < 4 ? 2'd0 : r < 7 ? 2'd1 : 2'd2;
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      e = op == 2'd3 ? 8'h00 : op == 2'd2 ? m[a] + 8'd1 : (op == 2'd1 && BYP) ? d : m[a];
      cd = op == 2'd3 || (op == 2'd1 && BYP) || kn[a];
      issue(0, op, a, d, e, cd, $sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
